// File: rtl/ecc_pkg.sv
// Shared widths, FSM states and Hamming position helpers for the SECDED read path.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package ecc_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int MEM_WIDTH   = 39;
    localparam int ADDR_WIDTH  = 14;
    localparam int PARITY_BITS = 6;
    localparam int CNT_WIDTH   = 16;
    localparam int SYN_WIDTH   = PARITY_BITS + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_RESP,
        ST_SCRUB
    } state_t;

    // Hamming position of each data bit: every non-power-of-two position 3..38 in order.
    localparam logic [PARITY_BITS-1:0] DATA_POS [DATA_WIDTH] = '{
        6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };

    // Stored parity bits XORed with the recomputed parity over the data field.
    function automatic logic [PARITY_BITS-1:0] calc_syndrome(input logic [MEM_WIDTH-1:0] w);
        logic [PARITY_BITS-1:0] s;
        s = w[MEM_WIDTH-1 -: PARITY_BITS];
        for (int i = 0; i < DATA_WIDTH; i++) begin
            s = s ^ (DATA_POS[i] & {PARITY_BITS{w[i]}});
        end
        return s;
    endfunction

    // Stored-word bit index addressed by a syndrome; zero syndrome means the overall bit.
    // Syndromes above 38 map nowhere and are never used to flip a bit.
    function automatic logic [5:0] locate_bit(input logic [PARITY_BITS-1:0] s);
        logic [5:0] idx;
        idx = 6'(DATA_WIDTH);
        for (int k = 0; k < PARITY_BITS; k++) begin
            if (s == (6'd1 << k)) idx = 6'(DATA_WIDTH + 1 + k);
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (s == DATA_POS[i]) idx = 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/data_dec_if.sv
// Read request/response and memory port bundle for the SECDED read-path decoder.
// Latency: n/a (wires only).
// Backpressure: response side is valid/ready; request side is req/gnt.
interface data_dec_if;
    import ecc_pkg::*;

    logic                  rd_req_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_gnt_o;
    logic                  mem_rd_en_o;
    logic [ADDR_WIDTH-1:0] mem_rd_addr_o;
    logic [MEM_WIDTH-1:0]  mem_rd_data_i;
    logic                  mem_wr_en_o;
    logic [ADDR_WIDTH-1:0] mem_wr_addr_o;
    logic [MEM_WIDTH-1:0]  mem_wr_data_o;
    logic                  rd_valid_o;
    logic                  rd_ready_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  sec_err_o;
    logic                  ded_err_o;
    logic [SYN_WIDTH-1:0]  syndrome_o;

    modport slave (
        input  rd_req_i, rd_addr_i, mem_rd_data_i, rd_ready_i,
        output rd_gnt_o, mem_rd_en_o, mem_rd_addr_o, mem_wr_en_o, mem_wr_addr_o,
               mem_wr_data_o, rd_valid_o, rd_data_o, sec_err_o, ded_err_o, syndrome_o
    );

    modport master (
        output rd_req_i, rd_addr_i, mem_rd_data_i, rd_ready_i,
        input  rd_gnt_o, mem_rd_en_o, mem_rd_addr_o, mem_wr_en_o, mem_wr_addr_o,
               mem_wr_data_o, rd_valid_o, rd_data_o, sec_err_o, ded_err_o, syndrome_o
    );
endinterface

// File: rtl/secded_check.sv
// Checks one stored word: syndrome, overall check, SEC/DED classification, corrected word.
// Latency: combinational.
// Backpressure: none.
module secded_check
    import ecc_pkg::*;
(
    input  logic [MEM_WIDTH-1:0]   word,
    output logic [PARITY_BITS-1:0] syndrome,
    output logic                   chk,
    output logic [MEM_WIDTH-1:0]   corr_word,
    output logic                   sec,
    output logic                   ded
);

    logic [5:0] loc;

    assign syndrome = calc_syndrome(word);
    assign chk      = ^word;
    assign loc      = locate_bit(syndrome);

    // Odd error count with a syndrome that names a real bit is correctable; anything else is not.
    assign sec = chk && (syndrome <= 6'(MEM_WIDTH - 1));
    assign ded = (!chk && (syndrome != '0)) || (chk && (syndrome > 6'(MEM_WIDTH - 1)));

    assign corr_word = sec ? (word ^ (MEM_WIDTH'(1) << loc)) : word;

endmodule

// File: rtl/data_dec.sv
// SECDED read path: fetch a stored word, correct/flag it, return data, optionally scrub back.
// Latency: request accepted at edge N, response valid from edge N+3.
// Backpressure: response held until rd_ready_i; rd_gnt_o low until the transaction (and scrub) ends.
module data_dec
    import ecc_pkg::*;
#(
    parameter int SCRUB_EN = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ECC_en,
    input  logic                 cnt_clr_i,
    data_dec_if.slave            bus,
    output logic [CNT_WIDTH-1:0] sec_cnt_o,
    output logic [CNT_WIDTH-1:0] ded_cnt_o
);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-3:0]   waddr_q;
    logic [MEM_WIDTH-1:0]    raw_q;
    logic                    ecc_q;
    logic                    resp_vld_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    sec_q;
    logic                    ded_q;
    logic [SYN_WIDTH-1:0]    syn_q;
    logic [MEM_WIDTH-1:0]    scrub_q;
    logic [CNT_WIDTH-1:0]    sec_cnt_q;
    logic [CNT_WIDTH-1:0]    ded_cnt_q;

    logic [PARITY_BITS-1:0]  syndrome;
    logic                    chk;
    logic [MEM_WIDTH-1:0]    corr_word;
    logic                    sec;
    logic                    ded;
    logic                    load_resp;
    logic                    resp_done;
    logic                    unused_addr_lsb;

    secded_check u_check (
        .word      (raw_q),
        .syndrome  (syndrome),
        .chk       (chk),
        .corr_word (corr_word),
        .sec       (sec),
        .ded       (ded)
    );

    // First RESP cycle decodes the captured word; the response is visible from the next edge.
    assign load_resp = (state == ST_RESP) && !resp_vld_q;
    assign resp_done = (state == ST_RESP) && resp_vld_q && bus.rd_ready_i;

    // State register; reset abandons any in-flight response or scrub.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: one read strobe, one capture cycle, response, optional scrub write.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.rd_req_i) state_nxt = ST_RD;
            ST_RD:    state_nxt = ST_CAP;
            ST_CAP:   state_nxt = ST_RESP;
            ST_RESP:  if (resp_done) begin
                          if (sec_q && ecc_q && (SCRUB_EN != 0)) state_nxt = ST_SCRUB;
                          else                                   state_nxt = ST_IDLE;
                      end
            ST_SCRUB: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Address, captured word and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            waddr_q    <= '0;
            raw_q      <= '0;
            ecc_q      <= 1'b0;
            resp_vld_q <= 1'b0;
            data_q     <= '0;
            sec_q      <= 1'b0;
            ded_q      <= 1'b0;
            syn_q      <= '0;
            scrub_q    <= '0;
        end else begin
            if ((state == ST_IDLE) && bus.rd_req_i) waddr_q <= bus.rd_addr_i[ADDR_WIDTH-1:2];
            if (state == ST_CAP) begin
                raw_q <= bus.mem_rd_data_i;
                ecc_q <= ECC_en;
            end
            if (load_resp) begin
                resp_vld_q <= 1'b1;
                data_q     <= ecc_q ? corr_word[DATA_WIDTH-1:0] : raw_q[DATA_WIDTH-1:0];
                sec_q      <= ecc_q && sec;
                ded_q      <= ecc_q && ded;
                syn_q      <= ecc_q ? {chk, syndrome} : '0;
                scrub_q    <= corr_word;
            end else if (resp_done) begin
                resp_vld_q <= 1'b0;
            end
        end
    end

    // Saturating event counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else begin
            if (load_resp && ecc_q && sec && (sec_cnt_q != '1)) sec_cnt_q <= sec_cnt_q + 1'b1;
            if (load_resp && ecc_q && ded && (ded_cnt_q != '1)) ded_cnt_q <= ded_cnt_q + 1'b1;
        end
    end

    assign bus.rd_gnt_o      = (state == ST_IDLE);
    assign bus.mem_rd_en_o   = (state == ST_RD);
    assign bus.mem_rd_addr_o = (state == ST_RD) ? {2'b00, waddr_q} : '0;
    assign bus.mem_wr_en_o   = (state == ST_SCRUB);
    assign bus.mem_wr_addr_o = (state == ST_SCRUB) ? {2'b00, waddr_q} : '0;
    assign bus.mem_wr_data_o = (state == ST_SCRUB) ? scrub_q : '0;
    assign bus.rd_valid_o    = resp_vld_q;
    assign bus.rd_data_o     = data_q;
    assign bus.sec_err_o     = sec_q;
    assign bus.ded_err_o     = ded_q;
    assign bus.syndrome_o    = syn_q;
    assign sec_cnt_o         = sec_cnt_q;
    assign ded_cnt_o         = ded_cnt_q;

    assign unused_addr_lsb = ^bus.rd_addr_i[1:0];

endmodule
